// File: rtl/shift_normalizer_pkg.sv
// Shared constants for the shift units: FSM state codes, default operand width
// and the normalization mode type.
package shift_normalizer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } norm_mode_e;

endpackage

// File: rtl/shift_normalizer_norm_detect.sv
// norm_detect: combinational flag that is high when a value is already
// normalized for the given mode (unsigned: MSB set; signed: MSB != next bit).
module shift_normalizer_norm_detect
    import shift_normalizer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  norm_mode_e       mode,
    output logic             norm
);

    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
    localparam logic [WIDTH-1:0] UNS_THRESH = ONE << (WIDTH - 1);
    localparam logic [WIDTH-1:0] SGN_THRESH = ONE << (WIDTH - 2);

    logic [WIDTH-1:0] folded;

    // Folding the sign into a magnitude turns both modes into one threshold compare.
    always_comb begin
        folded = value;
        norm   = 1'b0;
        if (mode == MODE_SIGNED) begin
            folded = value ^ {WIDTH{value[WIDTH-1]}};
            norm   = (folded >= SGN_THRESH);
        end else begin
            norm   = (folded >= UNS_THRESH);
        end
    end

endmodule

// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer: finds the left shift that normalizes an operand,
// one bit per cycle, and returns the shifted value with the shift count.
module shift_normalizer
    import shift_normalizer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             al,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic [SHW-1:0]   shamt,
    output logic             zero
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    norm_mode_e       mode_q, mode_d;
    logic             zero_q, zero_d;
    logic             norm;

    shift_normalizer_norm_detect #(.WIDTH(WIDTH)) u_norm_detect (
        .value (reg_q),
        .mode  (mode_q),
        .norm  (norm)
    );

    always_comb begin
        // NOTE: every next-state value starts as a hold so no path leaves it unassigned (no latch).
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    reg_d   = din;
                    cnt_d   = '0;
                    mode_d  = norm_mode_e'(al);
                    zero_d  = (din == '0);
                    state_d = (din == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A nonzero operand normalizes within WIDTH-1 shifts, so cnt cannot wrap.
                if (norm) begin
                    state_d = S_DONE;
                end else begin
                    reg_d = reg_q << 1;
                    cnt_d = cnt_q + SHW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            reg_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_UNSIGNED;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign dout      = reg_q;
    assign shamt     = cnt_q;
    assign zero      = zero_q;

    // Golden checks: a presented result is normalized (or a clean zero) and holds under backpressure.
    a_done_normalized: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> (zero_q ? (reg_q == '0 && cnt_q == '0) : norm));

    a_hold_under_backpressure: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(reg_q) && $stable(cnt_q) && $stable(zero_q)));

    a_legal_state: assert property (@(posedge clk) disable iff (!rst_n)
        state_q != 2'd3);

endmodule

// File: tb/tb_shift_normalizer.sv
// Bench for shift_normalizer: directed vectors with literal expectations plus a
// queue-based reference model compared on every cycle a result is presented.
module tb_shift_normalizer;

    localparam int W   = 8;
    localparam int SHW = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   din = '0;
    logic           al = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   dout;
    logic [SHW-1:0] shamt;
    logic           zero;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit rand_mode = 1'b0;

    typedef struct {
        logic [W-1:0] d;
        logic         a;
        int           acc;
    } op_t;

    op_t q[$];
    bit  head_seen = 1'b0;
    int  n_acc = 0;
    int  n_res = 0;
    int  n_dropped = 0;

    shift_normalizer #(.WIDTH(W), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .al        (al),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .shamt     (shamt),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp_v, exp_v);
        end
    endtask

    function automatic bit is_norm(input logic [W-1:0] v, input logic a);
        if (a) return v[W-1] != v[W-2];
        return v[W-1];
    endfunction

    // Reference: shift left until normalized; zero operands are reported as-is.
    function automatic void golden(input logic [W-1:0] d, input logic a,
                                   output logic [W-1:0] od, output int sh, output logic z);
        z  = (d == '0);
        od = d;
        sh = 0;
        if (!z) begin
            while (!is_norm(od, a)) begin
                od = od << 1;
                sh++;
            end
        end
    endfunction

    // Compare process: every presented result against the head of the model queue.
    always @(negedge clk) begin
        logic [W-1:0] ed;
        int           es;
        logic         ez;
        if (!rst_n) begin
            n_dropped += q.size();
            q.delete();
            head_seen = 1'b0;
        end else begin
            check("ready_valid_exclusive", int'(in_ready & out_valid), 0);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("result_without_operand", 1, 0);
                end else begin
                    golden(q[0].d, q[0].a, ed, es, ez);
                    check("mon_dout", int'(dout), int'(ed));
                    check("mon_shamt", int'(shamt), es);
                    check("mon_zero", int'(zero), int'(ez));
                    if (!head_seen) begin
                        head_seen = 1'b1;
                        check("mon_latency", cyc - q[0].acc + 1, ez ? 1 : es + 2);
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        head_seen = 1'b0;
                        n_res++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back('{din, al, cyc + 1});
                n_acc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [W-1:0] d, input logic a);
        int n = 0;
        in_valid = 1'b1;
        din      = d;
        al       = a;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 100);
    endtask

    task automatic run_one(input logic [W-1:0] d, input logic a, input logic [W-1:0] e_dout,
                           input int e_shamt, input logic e_zero, input int e_lat);
        int n;
        send(d, a);
        wait_valid(n);
        check($sformatf("lat_%02h_%0d", d, a), n, e_lat);
        check($sformatf("dout_%02h_%0d", d, a), int'(dout), int'(e_dout));
        check($sformatf("shamt_%02h_%0d", d, a), int'(shamt), e_shamt);
        check($sformatf("zero_%02h_%0d", d, a), int'(zero), int'(e_zero));
        tick();
        check("in_ready_after_take", int'(in_ready), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_dout"}, int'(dout), 0);
        check({tag, "_shamt"}, int'(shamt), 0);
        check({tag, "_zero"}, int'(zero), 0);
    endtask

    initial begin
        int           n;
        logic [W-1:0] md;
        int           ms;
        logic         mz;

        // Pin the model itself against hand-computed values.
        golden(8'h03, 1'b1, md, ms, mz);
        check("model_03_signed_dout", int'(md), 8'h60);
        check("model_03_signed_shamt", ms, 5);
        golden(8'h01, 1'b0, md, ms, mz);
        check("model_01_unsigned_shamt", ms, 7);

        #1;
        check_reset_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;

        run_one(8'h01, 1'b0, 8'h80, 7, 1'b0, 9);
        run_one(8'h80, 1'b0, 8'h80, 0, 1'b0, 2);
        run_one(8'h00, 1'b0, 8'h00, 0, 1'b1, 1);
        run_one(8'h00, 1'b1, 8'h00, 0, 1'b1, 1);
        run_one(8'hF0, 1'b1, 8'h80, 3, 1'b0, 5);
        run_one(8'h03, 1'b1, 8'h60, 5, 1'b0, 7);
        run_one(8'hFF, 1'b1, 8'h80, 7, 1'b0, 9);
        run_one(8'h40, 1'b1, 8'h40, 0, 1'b0, 2);

        // Backpressure: result held, next operand waits for the handshake.
        out_ready = 1'b0;
        send(8'h10, 1'b0);
        wait_valid(n);
        check("bp_latency", n, 5);
        tick();
        in_valid = 1'b1;
        din      = 8'h01;
        al       = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_dout", int'(dout), 8'h80);
            check("bp_shamt", int'(shamt), 3);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_idle_in_ready", int'(in_ready), 1);
        check("bp_idle_out_valid", int'(out_valid), 0);
        tick();
        in_valid = 1'b0;
        wait_valid(n);
        check("bp_next_latency", n, 9);
        check("bp_next_dout", int'(dout), 8'h80);
        check("bp_next_shamt", int'(shamt), 7);
        tick();

        // Reset two cycles into SHIFT discards the operation.
        send(8'h01, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        tick();
        check_reset_outputs("midrst_hold");
        rst_n = 1'b1;
        run_one(8'h02, 1'b0, 8'h80, 6, 1'b0, 8);

        // Randomized throughput with gaps and random consumer stalls.
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] rd;
            repeat ($urandom_range(0, 2)) tick();
            rd = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(0, 255));
            send(rd, 1'($urandom_range(0, 1)));
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_empty", q.size(), 0);
        check("one_result_per_accept", n_res + n_dropped, n_acc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
